// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle between a requester and the serial adder
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: 1-bit full adder built from two half-adder stages
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic s1, c1, c2;
    assign s1 = a ^ b;
    assign c1 = a & b;
    assign s  = s1 ^ cin;
    assign c2 = s1 & cin;
    assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell over WIDTH bits, LSB first, with a done pulse
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic clk,
    input logic rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, s, co, busy_q, done_q, cout_q;
    serial_fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry_q), .s(s), .co(co));
    // new bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign res_nxt = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sh    <= bus.a;
                    b_sh    <= bus.b;
                    carry_q <= 1'b0;
                    cnt     <= '0;
                    busy_q  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= co;
                    res     <= res_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= res_nxt;
                        cout_q <= co;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial adder at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_sum = 8'h00;
    logic last_cout = 1'b0;
    always #5 clk = ~clk;
    serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) i1 ();
    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i8.start = 1'b0; i8.a = '0; i8.b = '0;
        i1.start = 1'b0; i1.a = '0; i1.b = '0;
        #12;
        n_cmp++;
        if ({i8.busy, i8.done, i8.sum, i8.cout} !== 11'd0) begin
            n_err++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b want all 0", i8.busy, i8.done, i8.sum, i8.cout);
        end
        n_cmp++;
        if ({i1.busy, i1.done, i1.sum, i1.cout} !== 4'd0) begin
            n_err++;
            $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b want all 0", i1.busy, i1.done, i1.sum, i1.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es, input logic ec, input string nm);
        i8.a = a; i8.b = b; i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        n_cmp++;
        if (i8.busy !== 1'b1 || i8.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%b done=%b want 1/0", nm, i8.busy, i8.done);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            n_cmp++;
            if (i8.busy !== 1'b1 || i8.done !== 1'b0 || i8.sum !== last_sum || i8.cout !== last_cout) begin
                n_err++;
                $display("FAIL %s run E%0d: busy=%b done=%b sum=%h cout=%b want 1/0/%h/%b", nm, i, i8.busy, i8.done, i8.sum, i8.cout, last_sum, last_cout);
            end
        end
        step();
        n_cmp++;
        if (i8.busy !== 1'b1 || i8.done !== 1'b1 || i8.sum !== es || i8.cout !== ec) begin
            n_err++;
            $display("FAIL %s done: busy=%b done=%b sum=%h cout=%b want 1/1/%h/%b", nm, i8.busy, i8.done, i8.sum, i8.cout, es, ec);
        end
        last_sum = es; last_cout = ec;
        step();
        n_cmp++;
        if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.sum !== es || i8.cout !== ec) begin
            n_err++;
            $display("FAIL %s idle: busy=%b done=%b sum=%h cout=%b want 0/0/%h/%b", nm, i8.busy, i8.done, i8.sum, i8.cout, es, ec);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last_t = -1;
        i8.a = 8'h10; i8.b = 8'h22; i8.start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            step();
            if (i8.done === 1'b1) begin
                n_cmp++;
                if (i8.sum !== 8'h32 || i8.cout !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b result t=%0d: sum=%h cout=%b want 32/0", t, i8.sum, i8.cout);
                end
                n_cmp++;
                if ((pulses == 0 && t != 8) || (pulses > 0 && t - last_t != 10)) begin
                    n_err++;
                    $display("FAIL b2b spacing: pulse at t=%0d prev=%0d want first 8 then every 10", t, last_t);
                end
                last_sum = 8'h32; last_cout = 1'b0;
                pulses++;
                last_t = t;
            end else begin
                n_cmp++;
                if (i8.sum !== last_sum || i8.cout !== last_cout) begin
                    n_err++;
                    $display("FAIL b2b hold t=%0d: sum=%h cout=%b want %h/%b", t, i8.sum, i8.cout, last_sum, last_cout);
                end
            end
        end
        i8.start = 1'b0;
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL b2b count: pulses=%0d want 3", pulses);
        end
    endtask

    task automatic test_mid_start();
        i8.a = 8'h35; i8.b = 8'h4A; i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin i8.start = 1'b1; i8.a = 8'h00; i8.b = 8'h00; end
            if (i == 6) i8.start = 1'b0;
            step();
            n_cmp++;
            if (i < 8 && (i8.done !== 1'b0 || i8.busy !== 1'b1)) begin
                n_err++;
                $display("FAIL mid E%0d: busy=%b done=%b want 1/0", i, i8.busy, i8.done);
            end else if (i == 8 && (i8.done !== 1'b1 || i8.sum !== 8'h7F || i8.cout !== 1'b0)) begin
                n_err++;
                $display("FAIL mid done: done=%b sum=%h cout=%b want 1/7f/0", i8.done, i8.sum, i8.cout);
            end
        end
        last_sum = 8'h7F; last_cout = 1'b0;
        step();
        step();
        n_cmp++;
        if (i8.busy !== 1'b0 || i8.done !== 1'b0) begin
            n_err++;
            $display("FAIL mid after: busy=%b done=%b want 0/0", i8.busy, i8.done);
        end
    endtask

    task automatic test_async_reset();
        i8.a = 8'hF0; i8.b = 8'h0F; i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({i8.busy, i8.done, i8.sum, i8.cout} !== 11'd0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b want all 0", i8.busy, i8.done, i8.sum, i8.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = 8'h00; last_cout = 1'b0;
        test_add8(8'h01, 8'h02, 8'h03, 1'b0, "post_reset");
    endtask

    task automatic test_width1(input logic a, input logic b, input logic es, input logic ec);
        i1.a = a; i1.b = b; i1.start = 1'b1;
        step();
        i1.start = 1'b0;
        n_cmp++;
        if (i1.busy !== 1'b1 || i1.done !== 1'b0) begin
            n_err++;
            $display("FAIL w1 %b%b accept: busy=%b done=%b want 1/0", a, b, i1.busy, i1.done);
        end
        step();
        n_cmp++;
        if (i1.done !== 1'b1 || i1.sum !== es || i1.cout !== ec) begin
            n_err++;
            $display("FAIL w1 %b%b done: done=%b sum=%b cout=%b want 1/%b/%b", a, b, i1.done, i1.sum, i1.cout, es, ec);
        end
        step();
        n_cmp++;
        if (i1.busy !== 1'b0 || i1.done !== 1'b0) begin
            n_err++;
            $display("FAIL w1 %b%b idle: busy=%b done=%b want 0/0", a, b, i1.busy, i1.done);
        end
    endtask

    initial begin
        test_reset();
        test_add8(8'h35, 8'h4A, 8'h7F, 1'b0, "add_35_4a");
        test_add8(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        test_add8(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");
        test_back_to_back();
        test_mid_start();
        test_async_reset();
        test_width1(1'b0, 1'b0, 1'b0, 1'b0);
        test_width1(1'b0, 1'b1, 1'b1, 1'b0);
        test_width1(1'b1, 1'b0, 1'b1, 1'b0);
        test_width1(1'b1, 1'b1, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
